// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants and the rx_control state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package eth_pkg;

    localparam int ETH_MIN_LEN = 64;     // minimum legal frame, FCS included
    localparam int ETH_MAX_LEN = 1518;   // maximum legal frame, FCS included
    localparam int ETH_LEN_W   = 16;     // length counter width
    localparam int FCS_LEN     = 4;      // trailing CRC bytes

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2,
        DONE = 2'd3
    } rx_state_t;

endpackage

// File: rtl/rx_control_if.sv
// MAC RX byte stream plus frame-buffer write/status bundle for rx_control.
// Latency: none (wires only).
// Backpressure: buff_full is the only stall indication; the MAC side cannot be stalled.
interface rx_control_if #(
    parameter int LEN_W = 16
) ();

    logic [7:0]       rx_data;
    logic             rx_data_valid;
    logic             rx_last_byte;
    logic             rx_error;
    logic             buff_full;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic [LEN_W-1:0] frm_len;
    logic             frm_commit;
    logic             frm_discard;
    logic             overflow;

    // Environment side: MAC stream and buffer fullness in, buffer writes and status out
    modport master (
        output rx_data, rx_data_valid, rx_last_byte, rx_error, buff_full,
        input  wr_en, wr_data, frm_len, frm_commit, frm_discard, overflow
    );

    // rx_control side
    modport slave (
        input  rx_data, rx_data_valid, rx_last_byte, rx_error, buff_full,
        output wr_en, wr_data, frm_len, frm_commit, frm_discard, overflow
    );

endinterface

// File: rtl/rx_fcs_delay.sv
// Four-deep byte delay line with per-stage valid bits; holds back the trailing FCS bytes.
// Latency: a byte leaves when the fourth byte after it is pushed; out_* is combinational from the oldest stage.
// Backpressure: none; flush drops all held bytes and wins over a simultaneous push.
module rx_fcs_delay
    import eth_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       flush,
    input  logic [7:0] din,
    output logic       out_vld,
    output logic [7:0] out_dat
);

    logic [FCS_LEN-1:0][7:0] dat_q;
    logic [FCS_LEN-1:0]      vld_q;

    // Shift a new byte in on push; flush only clears the valid bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dat_q <= '0;
            vld_q <= '0;
        end else begin
            if (flush) begin
                vld_q <= '0;
            end else if (push) begin
                vld_q <= {vld_q[FCS_LEN-2:0], 1'b1};
            end
            if (push) begin
                dat_q <= {dat_q[FCS_LEN-2:0], din};
            end
        end
    end

    assign out_vld = vld_q[FCS_LEN-1];
    assign out_dat = dat_q[FCS_LEN-1];

endmodule

// File: rtl/rx_control.sv
// Receive frame control: writes MAC bytes to the frame buffer, checks length/error/overflow, ends each frame with one commit or discard pulse.
// Latency: write one cycle after a byte is accepted (after the fourth following byte with RX_FCS_STRIP_EN); status two cycles after the last byte.
// Backpressure: none toward the MAC; buff_full at write time loses the frame (DROP) and sets sticky overflow.
module rx_control
    import eth_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int MAX_LEN = ETH_MAX_LEN,
    parameter int LEN_W   = ETH_LEN_W
) (
    input  logic         clk,
    input  logic         rst,
    rx_control_if.slave  bus
);

    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    rx_state_t        state, state_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic             bad, bad_n;
    logic             ovf_q, ovf_n;
    logic             wr_en_q, wr_en_n;
    logic [7:0]       wr_data_q, wr_data_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic             commit_q, commit_n;
    logic             discard_q, discard_n;
    logic             take;
    logic             stop;

`ifdef RX_FCS_STRIP_EN
    logic       dly_push;
    logic       dly_flush;
    logic       dly_vld;
    logic [7:0] dly_dat;

    rx_fcs_delay u_fcs_delay (
        .clk     (clk),
        .rst     (rst),
        .push    (dly_push),
        .flush   (dly_flush),
        .din     (bus.rx_data),
        .out_vld (dly_vld),
        .out_dat (dly_dat)
    );
`endif

    // State, counter, flags and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bad       <= 1'b0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            len_q     <= '0;
            commit_q  <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bad       <= bad_n;
            ovf_q     <= ovf_n;
            wr_en_q   <= wr_en_n;
            wr_data_q <= wr_data_n;
            len_q     <= len_n;
            commit_q  <= commit_n;
            discard_q <= discard_n;
        end
    end

    // Next state: frame status in DONE, then byte acceptance (DONE behaves like IDLE for a new byte)
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bad_n     = bad;
        ovf_n     = ovf_q;
        wr_en_n   = 1'b0;
        wr_data_n = wr_data_q;
        len_n     = len_q;
        commit_n  = 1'b0;
        discard_n = 1'b0;
        take      = 1'b0;
        stop      = 1'b0;
`ifdef RX_FCS_STRIP_EN
        dly_push  = 1'b0;
        dly_flush = 1'b0;
`endif

        // The frame that just ended reports from registered cnt/bad, so a new
        // byte in this same cycle cannot disturb its status.
        if (state == DONE) begin
            state_n = IDLE;
            if (!bad && cnt >= MIN_L) begin
                commit_n = 1'b1;
`ifdef RX_FCS_STRIP_EN
                len_n    = cnt - LEN_W'(FCS_LEN);
`else
                len_n    = cnt;
`endif
            end else begin
                discard_n = 1'b1;
            end
        end

        if (bus.rx_data_valid) begin
            if (state == IDLE || state == DONE) begin
                cnt_n = LEN_W'(1);
                bad_n = bus.rx_error;
                take  = 1'b1;
            end else begin
                // Saturate at MAX_LEN+1 so an endless frame can never wrap to a legal length
                cnt_n = (cnt > MAX_L) ? cnt : cnt + LEN_W'(1);
                bad_n = bad | bus.rx_error;
                if (state == DROP || cnt >= MAX_L) begin
                    bad_n = 1'b1;
                    stop  = 1'b1;
                end else begin
                    take = 1'b1;
                end
            end

            if (take) begin
`ifdef RX_FCS_STRIP_EN
                // Buffer space matters only when a delayed byte actually leaves the line
                dly_push = 1'b1;
                if (dly_vld) begin
                    if (bus.buff_full) begin
                        ovf_n = 1'b1;
                        bad_n = 1'b1;
                        stop  = 1'b1;
                    end else begin
                        wr_en_n   = 1'b1;
                        wr_data_n = dly_dat;
                    end
                end
`else
                if (bus.buff_full) begin
                    ovf_n = 1'b1;
                    bad_n = 1'b1;
                    stop  = 1'b1;
                end else begin
                    wr_en_n   = 1'b1;
                    wr_data_n = bus.rx_data;
                end
`endif
            end

            if (bus.rx_last_byte) begin
                state_n = DONE;
            end else if (stop) begin
                state_n = DROP;
            end else begin
                state_n = RECV;
            end
`ifdef RX_FCS_STRIP_EN
            // Whatever is still held at frame end (or when the frame is lost) is FCS or dead
            dly_flush = bus.rx_last_byte | stop;
`endif
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frm_len     = len_q;
    assign bus.frm_commit  = commit_q;
    assign bus.frm_discard = discard_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: doc/rx_control.md
Name: rx_control

Overview:
Receive-side counterpart of the bridge's TX byte sender. Accepts a byte stream from the MAC RX interface, writes accepted bytes into the downstream frame buffer and counts frame length. Checks min/max length, rx error and buffer overflow, then ends every frame with exactly one commit or discard pulse, so the buffer can publish or rewind the frame.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (FCS included)
MAX_LEN, 1518, maximum legal frame length in bytes (FCS included)
LEN_W, 16, width of length counter and frm_len

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
rx_data  in  8  received byte from MAC
rx_data_valid  in  1  rx_data valid this cycle; no backpressure toward MAC
rx_last_byte  in  1  qualifies final byte of frame (meaningful only with rx_data_valid)
rx_error  in  1  MAC error flag for the current byte
buff_full  in  1  downstream buffer cannot take a write this cycle
wr_en  out  1  buffer write strobe
wr_data  out  8  byte to write
frm_len  out  LEN_W  length of last committed frame (bytes written)
frm_commit  out  1  one-cycle pulse: frame complete and valid
frm_discard  out  1  one-cycle pulse: frame bad, buffer rewinds to frame start
overflow  out  1  sticky: a frame was lost to buff_full; cleared only by reset

Behaviour:
- Reset (async, rst low): state IDLE; wr_en, wr_data, frm_len, frm_commit, frm_discard, overflow all 0; byte counter 0.
- Reset mid-frame: frame is abandoned with no commit or discard. Bytes arriving after reset release start a new frame; a truncated tail ends as a runt and is discarded.
- States:
  - IDLE: rx_data_valid -> byte accepted, cnt=1, go RECV (or DONE if rx_last_byte in the same cycle).
  - RECV: each valid byte increments cnt; rx_last_byte -> DONE.
  - DROP: swallow bytes with no writes; rx_last_byte -> DONE with bad flag set.
  - DONE: single cycle; issue status; back to IDLE. A valid byte arriving in DONE starts a new frame and is handled as in IDLE.
- Byte-accepted-at-edge-k timing:
  - wr_en=1 and wr_data=byte at k+1 (registered).
  - If the byte is last, frm_commit or frm_discard fires at k+2.
  - frm_len updates in the same cycle as frm_commit and holds until the next commit; it is unchanged on discard.
- Bad-frame conditions; any one sets bad and forces frm_discard:
  - rx_error on any byte, including the last.
  - buff_full while a byte is to be written: that byte is not written, go DROP, set overflow.
  - cnt would exceed MAX_LEN: that byte and later ones are not written, go DROP.
  - Final cnt < MIN_LEN.
- Counter saturates at MAX_LEN+1 and never wraps.
- Exactly one of frm_commit/frm_discard per frame; never both in one cycle.
- rx_last_byte without rx_data_valid is ignored.

Optional Feature:
RX_FCS_STRIP_EN
- Defined:
  - 4-byte delay line. A byte is written one cycle after the 4th following byte is accepted.
  - The final 4 bytes (FCS) are never written.
  - frm_len = cnt-4.
  - buff_full is sampled at the delayed write.
  - Length checks still use cnt including FCS.
- Undefined: every accepted byte is written at k+1; frm_len = cnt.

Decomposition:
- Shared package eth_pkg: MIN_LEN/MAX_LEN defaults, FCS_LEN=4, state enum {IDLE,RECV,DROP,DONE}.
- One natural sub-module: rx_fcs_delay (4-stage byte shift register with valid bits, flushable), instantiated only under RX_FCS_STRIP_EN.

Test Plan:
- 64-byte frame 0x00..0x3F, buff_full=0 -> 64 wr_en pulses with matching data; frm_commit 2 cycles after last byte, frm_len=64 (60 with RX_FCS_STRIP_EN, bytes 0x3C..0x3F not written).
- 20-byte runt -> 20 writes, then frm_discard; frm_len keeps its previous value.
- 100-byte frame with rx_error on byte 50 -> frm_discard after last byte, no commit.
- buff_full high on byte 10 of a 80-byte frame -> 9 writes only, overflow=1, frm_discard at end; the next clean 64-byte frame commits.
- 1600-byte frame -> exactly 1518 writes, frm_discard; back-to-back 64-byte frame starting in the DONE cycle commits with frm_len=64.
- rst low at byte 30 of a frame -> all outputs 0 immediately, no status pulse; the remainder of that frame is discarded as a runt.
